// File: rtl/flt2int_conv.sv
// Purpose : converts a half-precision float read from data memory into a
//           saturating, round-to-nearest-even 16-bit integer and stores it back.
// Latency : 7+n edges from the start-low sample to done (n = shift count), 6 for specials.
// Backpr. : none; the memory read is combinational and the writes are unconditional.
// Ports   : clk/reset (async, active low), start (arm on high, go on the following low),
//           mem_addr/mem_rd_data/mem_wr_en/mem_wr_data byte memory port,
//           int_out/ovf/inexact/done result, held until the next start.
module flt2int_conv #(
   parameter int ADDR_W   = 8,
   parameter int FLT_ADDR = 2,
   parameter int INT_ADDR = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic [15:0]       int_out,
   output logic              ovf,
   output logic              inexact,
   output logic              done
);

   typedef enum logic [3:0] {
      S_IDLE, S_LD_LO, S_LD_HI, S_DECODE, S_SHIFT, S_ROUND, S_ST_LO, S_ST_HI, S_FIN
   } state_t;

   state_t      state;
   logic        armed;
   logic [15:0] flt;
   logic [16:0] mag;
   logic        g_bit;
   logic        stk_bit;
   logic        shl;
   logic [3:0]  cnt;
   logic [15:0] res;

   logic        sgn;
   logic [4:0]  exp_f;
   logic [9:0]  man;
   logic [15:0] sat_val;

   assign sgn     = flt[15];
   assign exp_f   = flt[14:10];
   assign man     = flt[9:0];
   assign sat_val = sgn ? 16'h8000 : 16'h7FFF;

   // Decode: either a finished (special) result or a shift plan for the normal path.
   // The binary point of {1,M} sits 10 places in, so E=25 (e=10) needs no shift.
   logic [15:0] dec_res;
   logic        dec_ovf;
   logic        dec_inx;
   logic        dec_spec;
   logic        dec_shl;
   logic [3:0]  dec_cnt;

   always_comb begin
      dec_res  = '0;
      dec_ovf  = 1'b0;
      dec_inx  = 1'b0;
      dec_spec = 1'b1;
      dec_shl  = 1'b0;
      dec_cnt  = '0;
      if (exp_f == 5'd0) begin
         dec_inx = (man != 10'd0);                    // zero or subnormal
      end else if (exp_f == 5'd31) begin
         dec_res = (man == 10'd0 && !sgn) ? 16'h7FFF : 16'h8000;
         dec_ovf = 1'b1;                              // Inf / NaN
      end else if (exp_f == 5'd30) begin
         // -32768 is the only representable value with e=15
         if (sgn && man == 10'd0) begin
            dec_res = 16'h8000;
         end else begin
            dec_res = sat_val;
            dec_ovf = 1'b1;
         end
      end else if (exp_f >= 5'd25) begin
         dec_spec = 1'b0;
         dec_shl  = 1'b1;
         dec_cnt  = 4'(exp_f - 5'd25);
      end else if (exp_f >= 5'd13) begin
         dec_spec = 1'b0;
         dec_cnt  = 4'(5'd25 - exp_f);
      end else begin
         dec_inx = 1'b1;                              // below 0.25, rounds to zero
      end
   end

   // Round-to-nearest-even, then saturate or apply the sign.
   logic [16:0] mag_rnd;
   logic        rnd_sat;
   logic [15:0] rnd_res;

   always_comb begin
      mag_rnd = mag + {16'd0, g_bit & (stk_bit | mag[0])};
      rnd_sat = (mag_rnd > 17'd32767) && !(sgn && mag_rnd == 17'd32768);
      if (rnd_sat) begin
         rnd_res = sat_val;
      end else if (sgn) begin
         rnd_res = 16'd0 - mag_rnd[15:0];
      end else begin
         rnd_res = mag_rnd[15:0];
      end
   end

   // Memory port outputs are registered and set up on entry to the state that uses them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         armed       <= 1'b0;
         flt         <= '0;
         mag         <= '0;
         g_bit       <= 1'b0;
         stk_bit     <= 1'b0;
         shl         <= 1'b0;
         cnt         <= '0;
         res         <= '0;
         mem_addr    <= '0;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= '0;
         int_out     <= '0;
         ovf         <= 1'b0;
         inexact     <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  armed   <= 1'b1;
                  done    <= 1'b0;
                  ovf     <= 1'b0;
                  inexact <= 1'b0;
               end else if (armed) begin
                  armed    <= 1'b0;
                  mem_addr <= ADDR_W'(FLT_ADDR);
                  state    <= S_LD_LO;
               end
            end
            S_LD_LO: begin
               flt[7:0] <= mem_rd_data;
               mem_addr <= ADDR_W'(FLT_ADDR + 1);
               state    <= S_LD_HI;
            end
            S_LD_HI: begin
               flt[15:8] <= mem_rd_data;
               mem_addr  <= '0;
               state     <= S_DECODE;
            end
            S_DECODE: begin
               mag     <= {6'd0, 1'b1, man};
               g_bit   <= 1'b0;
               stk_bit <= 1'b0;
               shl     <= dec_shl;
               cnt     <= dec_cnt;
               if (dec_spec) begin
                  res         <= dec_res;
                  ovf         <= dec_ovf;
                  inexact     <= dec_inx;
                  mem_addr    <= ADDR_W'(INT_ADDR);
                  mem_wr_en   <= 1'b1;
                  mem_wr_data <= dec_res[7:0];
                  state       <= S_ST_LO;
               end else begin
                  state <= (dec_cnt == 4'd0) ? S_ROUND : S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (shl) begin
                  mag <= mag << 1;
               end else begin
                  mag     <= mag >> 1;
                  g_bit   <= mag[0];
                  stk_bit <= stk_bit | g_bit;
               end
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= S_ROUND;
               end
            end
            S_ROUND: begin
               res         <= rnd_res;
               ovf         <= rnd_sat;
               inexact     <= g_bit | stk_bit;
               mem_addr    <= ADDR_W'(INT_ADDR);
               mem_wr_en   <= 1'b1;
               mem_wr_data <= rnd_res[7:0];
               state       <= S_ST_LO;
            end
            S_ST_LO: begin
               mem_addr    <= ADDR_W'(INT_ADDR + 1);
               mem_wr_data <= res[15:8];
               int_out     <= res;
               state       <= S_ST_HI;
            end
            S_ST_HI: begin
               mem_addr    <= '0;
               mem_wr_en   <= 1'b0;
               mem_wr_data <= '0;
               done        <= 1'b1;
               state       <= S_FIN;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flt2int_conv.sv
// Directed bench for flt2int_conv with a byte-wide behavioural data memory.
module tb_flt2int_conv;

   localparam int FLT_A = 2;
   localparam int INT_A = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_rd_data;
   logic        mem_wr_en;
   logic [7:0]  mem_wr_data;
   logic [15:0] int_out;
   logic        ovf;
   logic        inexact;
   logic        done;

   logic [7:0]  mem [256];
   int          wr_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   flt2int_conv #(.ADDR_W(8), .FLT_ADDR(FLT_A), .INT_ADDR(INT_A)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .int_out     (int_out),
      .ovf         (ovf),
      .inexact     (inexact),
      .done        (done)
   );

   assign mem_rd_data = mem[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) begin
         mem[mem_addr] = mem_wr_data;
         wr_cnt = wr_cnt + 1;
      end
   end

   // Loads f, pulses start, counts edges from the start-low sample until done.
   task automatic run_op(input logic [15:0] f, output logic [15:0] r, output logic o,
                         output logic ix, output int edges, output int writes);
      int wbase;
      mem[FLT_A]     = f[7:0];
      mem[FLT_A + 1] = f[15:8];
      mem[INT_A]     = 8'hEE;
      mem[INT_A + 1] = 8'hEE;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wbase = wr_cnt;
      edges = 0;
      do begin
         @(posedge clk);
         #1;
         edges++;
      end while (done !== 1'b1 && edges < 100);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL timeout f=%h: done=%b after %0d edges, required 1", f, done, edges);
      end
      r      = int_out;
      o      = ovf;
      ix     = inexact;
      writes = wr_cnt - wbase;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      #3 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({int_out, ovf, inexact, done, mem_wr_en, mem_addr, mem_wr_data} !== 36'd0) begin
         errors++;
         $display("FAIL reset_outputs: int=%h ovf=%b inx=%b done=%b we=%b addr=%h wd=%h, required all 0",
                  int_out, ovf, inexact, done, mem_wr_en, mem_addr, mem_wr_data);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_normal();
      logic [15:0] fv [3] = '{16'h3C00, 16'hBC00, 16'h77F8};
      logic [15:0] ev [3] = '{16'h0001, 16'hFFFF, 16'h7F80};
      int          lv [3] = '{17, 17, 11};
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      for (int i = 0; i < 3; i++) begin
         run_op(fv[i], r, o, ix, ed, wr);
         checks++;
         if (r !== ev[i] || o !== 1'b0 || ix !== 1'b0) begin
            errors++;
            $display("FAIL normal f=%h: int=%h ovf=%b inx=%b, required %h 0 0", fv[i], r, o, ix, ev[i]);
         end
         checks++;
         if (ed != lv[i]) begin
            errors++;
            $display("FAIL latency f=%h: %0d edges, required %0d", fv[i], ed, lv[i]);
         end
         checks++;
         if ({mem[INT_A + 1], mem[INT_A]} !== ev[i] || wr != 2) begin
            errors++;
            $display("FAIL mem_store f=%h: mem=%h writes=%0d, required %h 2",
                     fv[i], {mem[INT_A + 1], mem[INT_A]}, wr, ev[i]);
         end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (int_out !== 16'h7F80 || done !== 1'b1 || mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL hold: int=%h done=%b we=%b, required 7f80 1 0", int_out, done, mem_wr_en);
      end
   endtask

   task automatic test_rounding();
      logic [15:0] fv [3] = '{16'h3800, 16'h3E00, 16'h4100};
      logic [15:0] ev [3] = '{16'h0000, 16'h0002, 16'h0002};
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      for (int i = 0; i < 3; i++) begin
         run_op(fv[i], r, o, ix, ed, wr);
         checks++;
         if (r !== ev[i] || o !== 1'b0 || ix !== 1'b1) begin
            errors++;
            $display("FAIL round f=%h: int=%h ovf=%b inx=%b, required %h 0 1", fv[i], r, o, ix, ev[i]);
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] fv [5] = '{16'hF800, 16'h7800, 16'h7C00, 16'hFC00, 16'h7E00};
      logic [15:0] ev [5] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
      logic        ov [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      for (int i = 0; i < 5; i++) begin
         run_op(fv[i], r, o, ix, ed, wr);
         checks++;
         if (r !== ev[i] || o !== ov[i]) begin
            errors++;
            $display("FAIL saturate f=%h: int=%h ovf=%b, required %h %b", fv[i], r, o, ev[i], ov[i]);
         end
         checks++;
         if (ed != 6) begin
            errors++;
            $display("FAIL special_latency f=%h: %0d edges, required 6", fv[i], ed);
         end
      end
   endtask

   task automatic test_zero_subnormal();
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      run_op(16'h0000, r, o, ix, ed, wr);
      checks++;
      if (r !== 16'h0000 || o !== 1'b0 || ix !== 1'b0 || ed != 6) begin
         errors++;
         $display("FAIL zero: int=%h ovf=%b inx=%b edges=%0d, required 0000 0 0 6", r, o, ix, ed);
      end
      run_op(16'h8001, r, o, ix, ed, wr);
      checks++;
      if (r !== 16'h0000 || o !== 1'b0 || ix !== 1'b1 || wr != 2) begin
         errors++;
         $display("FAIL subnormal: int=%h ovf=%b inx=%b writes=%0d, required 0000 0 1 2", r, o, ix, wr);
      end
   endtask

   task automatic test_start_clears();
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      run_op(16'h7800, r, o, ix, ed, wr);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || ovf !== 1'b0 || inexact !== 1'b0) begin
         errors++;
         $display("FAIL start_clear: done=%b ovf=%b inx=%b, required 0 0 0", done, ovf, inexact);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || int_out !== 16'h7FFF) begin
         errors++;
         $display("FAIL restart: done=%b int=%h, required 1 7fff", done, int_out);
      end
   endtask

   task automatic test_reset_mid_shift();
      logic [15:0] r;
      logic        o, ix;
      int          ed, wr;
      mem[FLT_A]     = 8'h00;
      mem[FLT_A + 1] = 8'h3C;
      mem[INT_A]     = 8'hA5;
      mem[INT_A + 1] = 8'h5A;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({int_out, ovf, inexact, done, mem_wr_en, mem_addr, mem_wr_data} !== 36'd0) begin
         errors++;
         $display("FAIL reset_mid_op: int=%h ovf=%b inx=%b done=%b we=%b addr=%h wd=%h, required all 0",
                  int_out, ovf, inexact, done, mem_wr_en, mem_addr, mem_wr_data);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem[INT_A + 1], mem[INT_A]} !== 16'h5AA5 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_write: mem=%h done=%b, required 5aa5 0", {mem[INT_A + 1], mem[INT_A]}, done);
      end
      run_op(16'h4100, r, o, ix, ed, wr);
      checks++;
      if (r !== 16'h0002 || {mem[INT_A + 1], mem[INT_A]} !== 16'h0002 || ed != 16) begin
         errors++;
         $display("FAIL after_reset: int=%h mem=%h edges=%0d, required 0002 0002 16",
                  r, {mem[INT_A + 1], mem[INT_A]}, ed);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_normal();
      test_rounding();
      test_saturation();
      test_zero_subnormal();
      test_start_clears();
      test_reset_mid_shift();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
